// File: rtl/silife_pkg.sv
// Shared defaults, FSM encoding and sizing helper for the silife frame buffer.
package silife_pkg;

  localparam int SILIFE_WIDTH  = 32;
  localparam int SILIFE_HEIGHT = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CLEAR   = 2'd1,
    ST_PENDING = 2'd2
  } fb_state_t;

  function automatic int row_bits(input int height);
    return (height > 1) ? $clog2(height) : 1;
  endfunction

endpackage

// File: rtl/silife_frame_bank.sv
// One HEIGHT x WIDTH cell bank: single write/clear-row port, combinational read port.
module silife_frame_bank #(
  parameter int WIDTH    = 32,
  parameter int HEIGHT   = 32,
  parameter int ROW_BITS = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [ROW_BITS-1:0] wr_row,
  input  logic [WIDTH-1:0]    wr_data,
  input  logic [ROW_BITS-1:0] rd_row,
  output logic [WIDTH-1:0]    rd_data
);

  logic [WIDTH-1:0] mem [HEIGHT];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned r = 0; r < HEIGHT; r++) begin
        mem[r] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_row] <= wr_data;
    end
  end

  // Rows past HEIGHT only exist when HEIGHT is not a power of two; they read as empty.
  always_comb begin
    rd_data = '0;
    if (int'(rd_row) < HEIGHT) begin
      rd_data = mem[rd_row];
    end
  end

endmodule

// File: rtl/silife_frame_buffer.sv
// Double-buffered cell frame store: engine writes the back bank, display reads the front,
// banks swap only at a display frame boundary (or while the display is disabled).
module silife_frame_buffer
  import silife_pkg::*;
#(
  parameter int WIDTH    = SILIFE_WIDTH,
  parameter int HEIGHT   = SILIFE_HEIGHT,
  parameter int ROW_BITS = row_bits(HEIGHT)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_wr_en,
  input  logic [ROW_BITS-1:0] i_wr_row,
  input  logic [WIDTH-1:0]    i_wr_data,
  input  logic                i_wr_commit,
  input  logic                i_clear,
  input  logic                i_disp_enable,
  input  logic                i_rd_sync,
  input  logic [ROW_BITS-1:0] i_rd_row,
  output logic [WIDTH-1:0]    o_rd_cells,
  output logic                o_wr_ready,
  output logic                o_overrun,
  output logic [7:0]          o_frame_count
);

  fb_state_t           state;
  logic                fb;
  logic [ROW_BITS-1:0] clr_row;

  logic                wr_accept;
  logic                drop;
  logic                swap;
  logic                bank_we;
  logic [ROW_BITS-1:0] bank_row;
  logic [WIDTH-1:0]    bank_data;
  logic                we0;
  logic                we1;
  logic [WIDTH-1:0]    rd0;
  logic [WIDTH-1:0]    rd1;

  always_comb begin
    o_wr_ready = (state == ST_IDLE);
    wr_accept  = o_wr_ready && i_wr_en && (int'(i_wr_row) < HEIGHT);
    drop       = (!o_wr_ready && (i_wr_en || i_wr_commit || i_clear)) ||
                 (o_wr_ready && i_wr_commit && i_clear);
    swap       = (state == ST_PENDING) && (i_rd_sync || !i_disp_enable);
  end

  // Clearing reuses the bank write port, writing zeros to the row under the clear counter.
  always_comb begin
    bank_we   = wr_accept || (state == ST_CLEAR);
    bank_row  = (state == ST_CLEAR) ? clr_row : i_wr_row;
    bank_data = (state == ST_CLEAR) ? '0 : i_wr_data;
    we0       = bank_we && fb;
    we1       = bank_we && !fb;
    o_rd_cells = fb ? rd1 : rd0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      fb            <= 1'b0;
      clr_row       <= '0;
      o_overrun     <= 1'b0;
      o_frame_count <= '0;
    end else begin
      if (drop) begin
        o_overrun <= 1'b1;
      end
      unique case (state)
        ST_IDLE: begin
          if (i_wr_commit) begin
            state <= ST_PENDING;
          end else if (i_clear) begin
            state   <= ST_CLEAR;
            clr_row <= '0;
          end
        end
        ST_CLEAR: begin
          if (clr_row == ROW_BITS'(HEIGHT - 1)) begin
            state <= ST_IDLE;
          end else begin
            clr_row <= clr_row + ROW_BITS'(1);
          end
        end
        ST_PENDING: begin
          if (swap) begin
            fb            <= !fb;
            o_frame_count <= o_frame_count + 8'd1;
            state         <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  silife_frame_bank #(
    .WIDTH    (WIDTH),
    .HEIGHT   (HEIGHT),
    .ROW_BITS (ROW_BITS)
  ) u_bank0 (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (we0),
    .wr_row  (bank_row),
    .wr_data (bank_data),
    .rd_row  (i_rd_row),
    .rd_data (rd0)
  );

  silife_frame_bank #(
    .WIDTH    (WIDTH),
    .HEIGHT   (HEIGHT),
    .ROW_BITS (ROW_BITS)
  ) u_bank1 (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (we1),
    .wr_row  (bank_row),
    .wr_data (bank_data),
    .rd_row  (i_rd_row),
    .rd_data (rd1)
  );

endmodule

// File: tb/tb_silife_frame_buffer.sv
// Bench for silife_frame_buffer: front/back array model checked every cycle plus directed literals.
module tb_silife_frame_buffer;

  localparam int W  = 32;
  localparam int H  = 32;
  localparam int RB = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en;
  logic [RB-1:0] wr_row;
  logic [W-1:0]  wr_data;
  logic          wr_commit;
  logic          clear;
  logic          disp_en;
  logic          rd_sync;
  logic [RB-1:0] rd_row;
  logic [W-1:0]  rd_cells;
  logic          wr_ready;
  logic          overrun;
  logic [7:0]    frame_count;

  int total = 0;
  int bad   = 0;

  silife_frame_buffer #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk           (clk),
    .reset         (reset),
    .i_wr_en       (wr_en),
    .i_wr_row      (wr_row),
    .i_wr_data     (wr_data),
    .i_wr_commit   (wr_commit),
    .i_clear       (clear),
    .i_disp_enable (disp_en),
    .i_rd_sync     (rd_sync),
    .i_rd_row      (rd_row),
    .o_rd_cells    (rd_cells),
    .o_wr_ready    (wr_ready),
    .o_overrun     (overrun),
    .o_frame_count (frame_count)
  );

  always #5 clk = ~clk;

  // Model: two plain arrays that physically exchange contents on a swap.
  logic [W-1:0] m_front [H];
  logic [W-1:0] m_back  [H];
  logic [W-1:0] m_tmp;
  int           m_mode = 0;   // 0 writable, 1 clearing, 2 waiting for swap
  int           m_clr_left = 0;
  bit           m_over = 0;
  int           m_count = 0;
  bit           m_valid = 0;

  always @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < H; r++) begin
        m_front[r] = '0;
        m_back[r]  = '0;
      end
      m_mode  = 0;
      m_over  = 0;
      m_count = 0;
      m_valid = 1;
    end else if (m_valid) begin
      if (m_mode != 0 && (wr_en || wr_commit || clear)) m_over = 1;
      case (m_mode)
        0: begin
          if (wr_en && int'(wr_row) < H) m_back[wr_row] = wr_data;
          if (wr_commit) begin
            if (clear) m_over = 1;
            m_mode = 2;
          end else if (clear) begin
            for (int r = 0; r < H; r++) m_back[r] = '0;
            m_clr_left = H;
            m_mode = 1;
          end
        end
        1: begin
          m_clr_left--;
          if (m_clr_left == 0) m_mode = 0;
        end
        default: begin
          if (rd_sync || !disp_en) begin
            for (int r = 0; r < H; r++) begin
              m_tmp      = m_front[r];
              m_front[r] = m_back[r];
              m_back[r]  = m_tmp;
            end
            m_count = (m_count + 1) % 256;
            m_mode  = 0;
          end
        end
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_rd_cells", rd_cells, (int'(rd_row) < H) ? m_front[rd_row] : '0);
      chk("model_wr_ready", 32'(wr_ready), 32'(m_mode == 0));
      chk("model_overrun", 32'(overrun), 32'(m_over));
      chk("model_frame_count", 32'(frame_count), 32'(m_count));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    wr_en     = 1'b0;
    wr_commit = 1'b0;
    clear     = 1'b0;
    rd_sync   = 1'b0;
  endtask

  task automatic rd_check(input int row, input logic [31:0] exp, input string name);
    rd_row = RB'(row);
    #1;
    chk(name, rd_cells, exp);
  endtask

  task automatic write_row(input int row, input logic [31:0] data);
    wr_en   = 1'b1;
    wr_row  = RB'(row);
    wr_data = data;
    tick();
  endtask

  int n;

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_row = '0; wr_data = '0; wr_commit = 1'b0;
    clear = 1'b0; disp_en = 1'b1; rd_sync = 1'b0; rd_row = '0;
    tick();
    tick();
    reset = 1'b0;

    // 1. reset state
    for (int r = 0; r < H; r++) rd_check(r, 32'h0, "reset_row");
    chk("reset_ready", 32'(wr_ready), 32'd1);
    chk("reset_count", 32'(frame_count), 32'd0);
    chk("reset_overrun", 32'(overrun), 32'd0);

    // 2. write, commit, sync three cycles later
    write_row(5, 32'hDEADBEEF);
    wr_commit = 1'b1;
    tick();
    repeat (3) begin
      rd_check(5, 32'h0, "presync_row5");
      chk("presync_ready", 32'(wr_ready), 32'd0);
      tick();
    end
    rd_sync = 1'b1;
    tick();
    rd_check(5, 32'hDEADBEEF, "postsync_row5");
    chk("postsync_count", 32'(frame_count), 32'd1);
    chk("postsync_ready", 32'(wr_ready), 32'd1);

    // 3. display disabled: swap the cycle after commit without sync
    disp_en   = 1'b0;
    wr_commit = 1'b1;
    wr_en     = 1'b1;
    wr_row    = RB'(7);
    wr_data   = 32'h12345678;
    tick();
    chk("disabled_count_before", 32'(frame_count), 32'd1);
    tick();
    chk("disabled_count_after", 32'(frame_count), 32'd2);
    rd_check(7, 32'h12345678, "disabled_row7");
    rd_check(5, 32'h0, "disabled_row5");
    disp_en = 1'b1;

    // 4. write while pending is dropped
    write_row(2, 32'hAAAA5555);
    wr_commit = 1'b1;
    tick();
    chk("pend_overrun_clear", 32'(overrun), 32'd0);
    write_row(2, 32'h0BADF00D);
    chk("pend_overrun_set", 32'(overrun), 32'd1);
    rd_sync = 1'b1;
    tick();
    rd_check(2, 32'hAAAA5555, "swap3_row2");
    rd_check(5, 32'hDEADBEEF, "swap3_row5");
    wr_commit = 1'b1;
    tick();
    rd_sync = 1'b1;
    tick();
    rd_check(2, 32'h0, "swap4_row2_old");
    rd_check(7, 32'h12345678, "swap4_row7");
    chk("swap4_count", 32'(frame_count), 32'd4);

    // 5. fill back with ones, clear, measure busy window, then swap
    for (int r = 0; r < H; r++) write_row(r, 32'hFFFFFFFF);
    clear = 1'b1;
    tick();
    n = 0;
    while (!wr_ready && n < 100) begin
      n++;
      tick();
    end
    chk("clear_busy_cycles", 32'(n), 32'd32);
    wr_commit = 1'b1;
    tick();
    rd_sync = 1'b1;
    tick();
    for (int r = 0; r < H; r++) rd_check(r, 32'h0, "cleared_row");
    chk("clear_swap_count", 32'(frame_count), 32'd5);

    // 6. commit with sync in the same cycle waits for the next sync
    wr_commit = 1'b1;
    rd_sync   = 1'b1;
    tick();
    chk("samecyc_count", 32'(frame_count), 32'd5);
    chk("samecyc_ready", 32'(wr_ready), 32'd0);
    tick();
    chk("samecyc_still_pending", 32'(wr_ready), 32'd0);
    rd_sync = 1'b1;
    tick();
    chk("nextsync_count", 32'(frame_count), 32'd6);
    wr_commit = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("reset_pend_count", 32'(frame_count), 32'd0);
    chk("reset_pend_ready", 32'(wr_ready), 32'd1);
    chk("reset_pend_overrun", 32'(overrun), 32'd0);
    rd_check(7, 32'h0, "reset_pend_row7");

    // frame counter wraps after 256 swaps
    disp_en = 1'b0;
    repeat (256) begin
      wr_commit = 1'b1;
      tick();
      tick();
    end
    chk("count_wrap", 32'(frame_count), 32'd0);
    wr_commit = 1'b1;
    tick();
    tick();
    chk("count_after_wrap", 32'(frame_count), 32'd1);
    disp_en = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
